// File: rtl/maze_pkt_pkg.sv
// Shared packet layout and helpers for the maze merge stage.
package maze_pkt_pkg;

    localparam int PKT_W    = 23;
    localparam int TYPE_MSB = 22;
    localparam int TYPE_LSB = 21;
    localparam int QOS_BIT  = 20;
    localparam int SRC_MSB  = 19;
    localparam int SRC_LSB  = 14;
    localparam int TGT_MSB  = 13;
    localparam int TGT_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef struct packed {
        logic [1:0] ptype;
        logic       qos;
        logic [5:0] src;
        logic [5:0] tgt;
        logic [7:0] data;
    } pkt_t;

    // Which arbitration class (if any) wins this cycle.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_HI   = 2'd1,
        CLS_LO   = 2'd2
    } grant_cls_e;

    // Round-robin pointer advance: lane + 1, wrapping at n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int unsigned n);
        if (32'(v) + 32'd1 >= n) return '0;
        else                     return v + 3'd1;
    endfunction

endpackage

// File: rtl/maze_rr_pick.sv
// Round-robin picker: first asserted request at or after start, wrapping.
module maze_rr_pick #(
    parameter int N  = 7,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int unsigned lane;

    // Ascending search from start, first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        lane = 0;
        for (int unsigned k = 0; k < N; k++) begin
            lane = 32'(start) + k;
            if (lane >= N) lane = lane - N;
            if (!any && req[lane]) begin
                any       = 1'b1;
                gnt[lane] = 1'b1;
                idx       = PW'(lane);
            end
        end
    end

endmodule

// File: rtl/maze_xin_merge.sv
// QoS-aware round-robin merge of N_LANE input lanes into one registered stream.
module maze_xin_merge #(
    parameter int N_LANE     = 7,
    parameter int PKT_W      = 23,
    parameter int STARVE_LIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_LANE-1:0]       in_vld,
    output logic [N_LANE-1:0]       in_rdy,
    input  logic [N_LANE*PKT_W-1:0] in_pkt,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [PKT_W-1:0]        out_pkt,
    output logic [2:0]              out_lane,
    output logic                    starve_evt
);

    import maze_pkt_pkg::*;

    logic [N_LANE-1:0] hi_req, lo_req, hi_gnt, lo_gnt;
    logic [2:0]        hi_idx, lo_idx, sel_idx;
    logic              hi_any, lo_any;
    logic              slot_free, force_lo;
    grant_cls_e        cls;

    logic              out_vld_q, out_vld_d;
    logic [PKT_W-1:0]  out_pkt_q, out_pkt_d;
    logic [2:0]        out_lane_q, out_lane_d;
    logic [2:0]        ptr_hi_q, ptr_hi_d;
    logic [2:0]        ptr_lo_q, ptr_lo_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    // Split valid lanes into QoS classes from each packet's qos bit.
    always_comb begin
        hi_req = '0;
        lo_req = '0;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            hi_req[i] = in_vld[i] &  in_pkt[i*PKT_W + QOS_BIT];
            lo_req[i] = in_vld[i] & ~in_pkt[i*PKT_W + QOS_BIT];
        end
    end

    maze_rr_pick #(.N(N_LANE), .PW(3)) u_pick_hi (
        .req   (hi_req),
        .start (ptr_hi_q),
        .gnt   (hi_gnt),
        .idx   (hi_idx),
        .any   (hi_any)
    );

    maze_rr_pick #(.N(N_LANE), .PW(3)) u_pick_lo (
        .req   (lo_req),
        .start (ptr_lo_q),
        .gnt   (lo_gnt),
        .idx   (lo_idx),
        .any   (lo_any)
    );

    // Class select: hi wins unless the starvation guard forces a lo grant.
    always_comb begin
        slot_free = !out_vld_q || out_rdy;
        force_lo  = lo_any && (starve_cnt_q == 4'(STARVE_LIM));
        cls       = CLS_NONE;
        if (!rst && slot_free) begin
            if (hi_any && !force_lo) cls = CLS_HI;
            else if (lo_any)         cls = CLS_LO;
        end
    end

    // Grant, pointer, starvation counter and output register next state.
    always_comb begin
        in_rdy       = '0;
        starve_evt   = 1'b0;
        sel_idx      = '0;
        ptr_hi_d     = ptr_hi_q;
        ptr_lo_d     = ptr_lo_q;
        starve_cnt_d = starve_cnt_q;
        out_vld_d    = out_vld_q;
        out_pkt_d    = out_pkt_q;
        out_lane_d   = out_lane_q;

        case (cls)
            CLS_HI: begin
                in_rdy   = hi_gnt;
                sel_idx  = hi_idx;
                ptr_hi_d = wrap_inc(hi_idx, N_LANE);
            end
            CLS_LO: begin
                in_rdy     = lo_gnt;
                sel_idx    = lo_idx;
                ptr_lo_d   = wrap_inc(lo_idx, N_LANE);
                starve_evt = force_lo;
            end
            default: ;
        endcase

        // Counter is frozen while the output is stalled.
        if (slot_free) begin
            if (!lo_any || cls == CLS_LO)
                starve_cnt_d = '0;
            else if (cls == CLS_HI && starve_cnt_q != 4'(STARVE_LIM))
                starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (cls != CLS_NONE) begin
            out_vld_d  = 1'b1;
            out_pkt_d  = in_pkt[32'(sel_idx)*PKT_W +: PKT_W];
            out_lane_d = sel_idx;
        end else if (out_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q    <= 1'b0;
            out_pkt_q    <= '0;
            out_lane_q   <= '0;
            ptr_hi_q     <= '0;
            ptr_lo_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            out_vld_q    <= out_vld_d;
            out_pkt_q    <= out_pkt_d;
            out_lane_q   <= out_lane_d;
            ptr_hi_q     <= ptr_hi_d;
            ptr_lo_q     <= ptr_lo_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_pkt  = out_pkt_q;
    assign out_lane = out_lane_q;

endmodule
